// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state encoding, line levels and sizing helper for the UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Keeps the bit counter at least one bit wide for degenerate one-bit words.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: parallel request side and serial line of the UART transmitter.
interface uart_tx_ctrl_if #(parameter int WIDTH = 8);

    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_EN;
    logic             par_bit;
    logic             TX_OUT;
    logic             Busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, par_bit,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, par_bit,
        output TX_OUT, Busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shift register and bit counter feeding the data slots of a frame.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ser_bit_o,
    output logic             ser_done_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        sh_d  = load_i ? data_i : (shift_en_i ? sh_q >> 1 : sh_q);
        cnt_d = load_i ? '0 : (shift_en_i ? cnt_q + 1'b1 : cnt_q);
    end

    // Head of the next register value, so the registered line carries bit i in data slot i.
    assign ser_bit_o  = sh_d[0];
    assign ser_done_o = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame FSM and output mux; sends start, LSB-first data, optional parity and stop.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic              CLK,
    input logic              RST,
    uart_tx_ctrl_if.slave    bus
);

    tx_state_e state_q;
    logic      tx_q;
    logic      busy_q;
    logic      par_en_q;
    logic      load;
    logic      shift_en;
    logic      ser_bit;
    logic      ser_done;

    assign load     = (state_q == IDLE) && bus.DATA_VALID;
    assign shift_en = (state_q == DATA) && !ser_done;

    uart_tx_serializer #(.WIDTH(WIDTH)) u_ser (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (load),
        .shift_en_i (shift_en),
        .data_i     (bus.P_DATA),
        .ser_bit_o  (ser_bit),
        .ser_done_o (ser_done)
    );

    // Outputs are loaded with the level of the state being entered, so they move with the state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= bus.DATA_VALID ? START : IDLE;
                    tx_q     <= bus.DATA_VALID ? START_BIT : IDLE_LEVEL;
                    busy_q   <= bus.DATA_VALID;
                    par_en_q <= bus.DATA_VALID ? bus.PAR_EN : par_en_q;
                end
                START: begin
                    state_q <= DATA;
                    tx_q    <= ser_bit;
                end
                DATA: begin
                    state_q <= !ser_done ? DATA : (par_en_q ? PARITY : STOP);
                    tx_q    <= !ser_done ? ser_bit : (par_en_q ? bus.par_bit : STOP_BIT);
                end
                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= STOP_BIT;
                end
                STOP: begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit control and serializer stage: accepts a parallel word on a valid strobe and shifts out a complete asynchronous frame on one output line, LSB first. The frame is a start bit, WIDTH data bits, an optional parity bit and a stop bit. It sits directly downstream of the parity calculator: it drives the `Busy` that gates that block's data sampling and consumes its registered `par_bit` in the parity slot. `CLK` is the TX bit clock, one frame bit per `CLK` cycle.

## Interface
- `WIDTH`, default 8: data word width, in bits.

Ports:
- `CLK`  in  1  TX bit clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous and active-low.
- `P_DATA`  in  WIDTH  parallel data word; sampled only on the accept edge.
- `DATA_VALID`  in  1  request strobe; honoured only in IDLE.
- `PAR_EN`  in  1  parity enable; sampled on the accept edge, held for the frame.
- `par_bit`  in  1  parity bit from the parity calculator; already reflects PAR_TYP.
- `TX_OUT`  out  1  serial line, registered; idle level 1.
- `Busy`  out  1  registered; 1 from the accept edge to the end of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `TX_OUT`=1, `Busy`=0.
  - When `DATA_VALID`=1, the rising edge is the accept edge. On that edge: load `P_DATA` into the shift register, latch `PAR_EN`, clear the bit counter, set `Busy`=1, go to START.
- START: `TX_OUT`=0 for one cycle, then go to DATA.
- DATA:
  - `TX_OUT` = shift register bit 0; shift right each cycle; the counter increments 0..WIDTH-1.
  - When the counter reaches WIDTH-1: go to PARITY if the latched `PAR_EN`=1, otherwise go to STOP.
- PARITY: `TX_OUT` = `par_bit`, sampled in that cycle; one cycle, then go to STOP.
- STOP: `TX_OUT`=1 for one cycle, then go to IDLE. `Busy` clears on the same edge.
- `DATA_VALID` outside IDLE is ignored. No queuing, no error flag.
- `P_DATA` and `PAR_EN` changes after the accept edge do not affect the frame in flight.
- Counter width is $clog2(WIDTH). It is reset to 0 on every accept and never wraps inside a frame.
- Reset:
  - Values: state=IDLE, `TX_OUT`=1, `Busy`=0, counter=0, shift register=0.
  - An `RST` assertion mid-frame aborts the frame immediately and asynchronously. The line returns to 1 without a stop bit.
- Undefined state encodings go to IDLE with `TX_OUT`=1.

## Timing
- Accept edge = edge k. `TX_OUT` and `Busy` change on the same edges as the state register.
- Start bit: cycle k+1.
- Data bit i: cycle k+2+i.
- Parity: cycle k+2+WIDTH, only if enabled.
- Stop bit: the following cycle.
- Frame length: WIDTH+2 cycles, or WIDTH+3 with parity.
- `par_bit` handshake: the parity calculator samples `P_DATA` on the accept edge, because `Busy` is still 0 before it. Its `par_bit` is stable from edge k+1 onward, well before the parity slot. Raising `Busy` on edge k freezes its sample for the whole frame.
- Back-to-back: `Busy` is low for at least one cycle between frames. With `DATA_VALID` held at 1, frames are separated by exactly one idle cycle with `TX_OUT`=1.

## Structure
- Shared package `uart_tx_pkg`:
  - 3-bit state enum: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - Constants `START_BIT`=1'b0, `STOP_BIT`=1'b1, `IDLE_LEVEL`=1'b1.
- Sub-module `uart_tx_serializer`:
  - Contents: shift register plus bit counter.
  - Inputs: `load`, `shift_en`.
  - Outputs: `ser_bit`, `ser_done` (asserted when the counter reaches WIDTH-1).
- The top module holds the FSM and the output mux, which selects start, serial, parity or stop.

## Test plan
- 8'hA5, PAR_EN=1, par_bit driven by the parity calculator with PAR_TYP=0: `TX_OUT` from k+1 is 0,1,0,1,0,0,1,0,1,0,1. Parity bit 0, 11 cycles, `Busy`=1 throughout, then idle.
- 8'hA5, PAR_TYP=1: same frame with parity bit 1.
- 8'h3C, PAR_EN=0: `TX_OUT` is 0,0,0,1,1,1,1,0,0,1, 10 cycles. There is no parity slot.
- `DATA_VALID` held at 1 with 8'hFF then 8'h00, parity off:
  - Two frames separated by exactly one idle cycle.
  - The second frame carries 8'h00.
  - `DATA_VALID` pulses while `Busy`=1 are ignored.
- `RST` asserted during data bit 3 of 8'h55: `TX_OUT`=1 and `Busy`=0 immediately. After release, the next accept starts a clean frame.
- `P_DATA` changed from 8'h0F to 8'hF0 one cycle after accept: the transmitted bits are those of 8'h0F.
